// File: rtl/mips_pkg.sv
// Shared fetch-stage types: instruction width, NOP encoding, FSM and control encodings.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_TGT  = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_SQUASH = 2'd2
  } ifid_op_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with hold / +4 / aligned-target next-PC mux and sticky fault detect.
// Fault covers misaligned redirect targets and normal fetches beyond instruction memory.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  pc_sel_t     pc_sel,
  input  logic        fetch,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;

  logic [31:0] pc_d;
  logic        fault_set;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_d = pc;
    case (pc_sel)
      PC_INC:  pc_d = pc_plus4;
      PC_TGT:  pc_d = {target[31:2], 2'b00};
      default: pc_d = pc;
    endcase
  end

  // Out-of-range words are still fetched (memory aliases), only flagged.
  assign fault_set = ((pc_sel == PC_TGT) && (target[1:0] != 2'b00)) ||
                     (fetch && (pc >= IMEM_BYTES));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      pc <= pc_d;
      if (fault_set) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: BOOT/RUN/HALT FSM, IF/ID register and retired-fetch counter around fetch_pc_reg.
// One fetch per cycle; word at PC lands in IF/ID one edge later; stall holds PC and IF/ID.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               halted,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);

  fetch_state_t state_q, state_d;
  pc_sel_t      pc_sel;
  ifid_op_t     ifid_op;
  logic         count_inc;
  logic         fetch;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;

  fetch_pc_reg #(
    .RESET_PC  (RESET_PC),
    .IMEM_WORDS(IMEM_WORDS)
  ) u_pc (
    .clk     (Clk),
    .reset   (Reset),
    .pc_sel  (pc_sel),
    .fetch   (fetch),
    .target  (redirect_target),
    .pc      (pc),
    .pc_plus4(pc_plus4),
    .fault   (fetch_fault)
  );

  assign imem_addr = pc;
  assign halted    = (state_q == HALT);
  assign fetch     = (ifid_op == IFID_LOAD);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_sel    = PC_HOLD;
    ifid_op   = IFID_HOLD;
    count_inc = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        ifid_op = IFID_SQUASH;
      end
      RUN: begin
        // Redirect beats stall: the wrong-path slot is squashed, never held.
        if (redirect_valid) begin
          pc_sel  = PC_TGT;
          ifid_op = IFID_SQUASH;
        end else if (!stall) begin
          ifid_op   = IFID_LOAD;
          count_inc = 1'b1;
          if (imem_instr == HALT_WORD) begin
            state_d = HALT;
          end else begin
            pc_sel = PC_INC;
          end
        end
      end
      HALT: begin
        ifid_op = IFID_SQUASH;
        if (redirect_valid) begin
          pc_sel  = PC_TGT;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        ifid_op = IFID_SQUASH;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      case (ifid_op)
        IFID_LOAD: begin
          if_id_instr    <= imem_instr;
          if_id_pc_plus4 <= pc_plus4;
          if_id_valid    <= 1'b1;
        end
        IFID_SQUASH: begin
          if_id_instr <= NOP_WORD;
          if_id_valid <= 1'b0;
        end
        default: ;
      endcase
      if (count_inc) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench with a scoreboard queue of expected post-edge outputs,
// followed by a random-stall streaming run checked against a bench-side PC.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt_inj = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word index * 3, with an optional HALT word at 0x10.
  always_comb begin
    imem_instr = {22'b0, imem_addr[11:2]} * 32'd3;
    if (halt_inj && imem_addr == 32'h10) imem_instr = 32'hFFFF_FFFF;
  end

  instruction_fetch_unit dut (
    .Clk            (clk),
    .Reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        hinj;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        halted;
    logic        fault;
    logic [31:0] count;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic rv,
                              input logic [31:0] tgt, input logic hinj,
                              input logic [31:0] pc, input logic valid,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic hlt, input logic flt,
                              input logic [31:0] count);
    vec_t v;
    v.rst = rst; v.stall = stl; v.rv = rv; v.tgt = tgt; v.hinj = hinj;
    v.pc = pc; v.valid = valid; v.instr = instr; v.pc4 = pc4;
    v.halted = hlt; v.fault = flt; v.count = count;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    vec_t s;
    logic [31:0] mpc;
    logic [31:0] mcount;

    //        rst stl rv tgt           hinj  pc            v  instr         pc4           h  f  count
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h4,        0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h8,        1, 32'h3,        32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h3,        32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h3,        32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h3,        32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 32'h40,       0, 32'h40,       0, 32'h0,        32'h0,        0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h44,       1, 32'h30,       32'h44,       0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 32'h41,       0, 32'h40,       0, 32'h0,        32'h0,        0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h44,       1, 32'h30,       32'h44,       0, 1, 4));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h48,       1, 32'h33,       32'h48,       0, 1, 5));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h4,        0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h8,        1, 32'h3,        32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC,        1, 32'h6,        32'hC,        0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h9,        32'h10,       0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10,       1, 32'hFFFF_FFFF, 32'h14,      1, 0, 5));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0,        1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0,        1, 0, 5));
    vecs.push_back(mk(0, 0, 1, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h4,        0, 0, 6));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0,      32'h0,        0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hBFD,      32'h0,        0, 1, 7));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hBFD,      32'h0,        0, 1, 7));
    vecs.push_back(mk(1, 1, 1, 32'h80,       0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h80,       0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h4,        0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset           = vecs[i].rst;
      stall           = vecs[i].stall;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      halt_inj        = vecs[i].hinj;
      sbq.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check($sformatf("v%0d pc", i), imem_addr, e.pc);
      check($sformatf("v%0d valid", i), {31'b0, if_id_valid}, {31'b0, e.valid});
      check($sformatf("v%0d instr", i), if_id_instr, e.instr);
      if (e.valid || e.rst) check($sformatf("v%0d pc4", i), if_id_pc_plus4, e.pc4);
      check($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, e.halted});
      check($sformatf("v%0d fault", i), {31'b0, fetch_fault}, {31'b0, e.fault});
      check($sformatf("v%0d count", i), fetch_count, e.count);
    end

    // Streaming run with random stalls: every unstalled cycle retires the next sequential word.
    mpc    = 32'h4;
    mcount = 32'd1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      halt_inj       = 1'b0;
      stall          = 1'($urandom_range(0, 1));
      if (!stall) begin
        s.valid = 1'b1;
        s.instr = {22'b0, mpc[11:2]} * 32'd3;
        s.pc4   = mpc + 32'd4;
        sbq.push_back(s);
      end
      @(posedge clk);
      #1;
      if (!stall) begin
        e = sbq.pop_front();
        check($sformatf("s%0d instr", i), if_id_instr, e.instr);
        check($sformatf("s%0d pc4", i), if_id_pc_plus4, e.pc4);
        check($sformatf("s%0d valid", i), {31'b0, if_id_valid}, {31'b0, e.valid});
        mpc    = mpc + 32'd4;
        mcount = mcount + 32'd1;
      end
      check($sformatf("s%0d pc", i), imem_addr, mpc);
    end
    check("stream count", fetch_count, mcount);
    check("stream fault", {31'b0, fetch_fault}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
